// File: rtl/fan_duty_sched.sv
// rtl/fan_duty_sched.sv - humidity-zoned fan duty ramp controller with sensor watchdog; optional kick-start under FAN_KICK_EN
module fan_duty_sched #(
    parameter int PERIOD      = 1000,
    parameter int RAMP_STEP   = 50,
    parameter int RAMP_DIV    = 4,
    parameter int HYST        = 3,
    parameter int TIMEOUT_CYC = 100000000,
    parameter int FAULT_DUTY  = 999,
    parameter int KICK_CYC    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hum_valid,
    input  logic [7:0] humidity,
    input  logic       sensor_err,
    output logic [9:0] duty,
    output logic [1:0] zone,
    output logic       busy,
    output logic       fault
);

    localparam logic [9:0]  TGT_Z0    = 10'((PERIOD - 1) * 20 / 100);
    localparam logic [9:0]  TGT_Z1    = 10'((PERIOD - 1) * 50 / 100);
    localparam logic [9:0]  TGT_Z2    = 10'((PERIOD - 1) * 80 / 100);
    localparam logic [9:0]  TGT_FAULT = 10'(FAULT_DUTY);
    localparam logic [10:0] STEP      = 11'(RAMP_STEP);
    localparam logic [9:0]  STEP10    = 10'(RAMP_STEP);
    localparam int          DIV_W     = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RAMP_DIV - 1);
    localparam int          WD_W      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
    localparam int          KICK_W    = (KICK_CYC > 1) ? $clog2(KICK_CYC) : 1;

    typedef enum logic [1:0] {S_WAIT, S_RAMP, S_HOLD, S_FAULT} state_t;

    state_t            state, state_nxt;
    logic [WD_W-1:0]   wd;
    logic [DIV_W-1:0]  div;
    logic [1:0]        err_cnt;
    logic [KICK_W-1:0] kick_cnt;
    logic              kick_active;
    logic              good, bad, err3, wd_expire, to_fault, first_sample;
    logic              ramping, ramp_tick;
    logic [8:0]        hum9, hum_hyst;
    logic [1:0]        raw_zone, hyst_zone, zone_nxt;
    logic [9:0]        target, duty_step;
    logic [10:0]       step_up, step_gap;

    function automatic logic [1:0] zone_of(input logic [8:0] h);
        logic [1:0] z;
        if (h < 9'd20)      z = 2'd0;
        else if (h < 9'd50) z = 2'd1;
        else if (h < 9'd80) z = 2'd2;
        else                z = 2'd3;
        return z;
    endfunction

    function automatic logic [9:0] target_of(input logic [1:0] z);
        logic [9:0] t;
        case (z)
            2'd0:    t = TGT_Z0;
            2'd1:    t = TGT_Z1;
            2'd2:    t = TGT_Z2;
            default: t = '0;
        endcase
        return t;
    endfunction

    // A reading over 100% is as untrustworthy as a checksum failure.
    assign good         = hum_valid && !sensor_err && (humidity <= 8'd100);
    assign bad          = hum_valid && !good;
    assign err3         = bad && (err_cnt == 2'd2);
    assign wd_expire    = (wd >= WD_LAST);
    assign to_fault     = !good && (wd_expire || err3);
    assign first_sample = (state == S_WAIT) || (state == S_FAULT);
    assign ramping      = (state == S_RAMP) || (state == S_FAULT);
    assign ramp_tick    = ramping && (div == DIV_LAST);
    assign hum9         = {1'b0, humidity};
    assign hum_hyst     = hum9 + 9'(HYST);
    assign raw_zone     = zone_of(hum9);
    assign hyst_zone    = zone_of(hum_hyst);
    assign target       = (state == S_FAULT) ? TGT_FAULT : target_of(zone);
    assign kick_active  = (kick_cnt != '0);
    assign busy         = (duty != target) || kick_active;
    assign fault        = (state == S_FAULT);

    // Zone follows rising humidity at once, falls only after clearing the hysteresis band.
    always_comb begin
        zone_nxt = zone;
        if (good) begin
            if (first_sample)            zone_nxt = raw_zone;
            else if (raw_zone > zone)    zone_nxt = raw_zone;
            else if (hyst_zone < zone)   zone_nxt = hyst_zone;
        end
    end

    // One ramp step toward target, clamped so it never overshoots.
    always_comb begin
        step_up  = {1'b0, duty} + STEP;
        step_gap = {1'b0, duty} - {1'b0, target};
        if (duty < target)
            duty_step = (step_up < {1'b0, target}) ? step_up[9:0] : target;
        else
            duty_step = (step_gap > STEP) ? (duty - STEP10) : target;
`ifdef FAN_KICK_EN
        if (kick_active && (target != '0))
            duty_step = duty;
        else if ((duty == '0) && (target != '0))
            duty_step = 10'(PERIOD - 1);
`endif
    end

    // Next-state selection; a good sample always outranks a watchdog expiry.
    always_comb begin
        state_nxt = state;
        case (state)
            S_WAIT: begin
                if (good)          state_nxt = S_RAMP;
                else if (to_fault) state_nxt = S_FAULT;
            end
            S_RAMP: begin
                if (to_fault)
                    state_nxt = S_FAULT;
                else if (!good && (duty == target) && !kick_active)
                    state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (good && (target_of(zone_nxt) != duty)) state_nxt = S_RAMP;
                else if (to_fault)                         state_nxt = S_FAULT;
            end
            S_FAULT: begin
                if (good) state_nxt = S_RAMP;
            end
            default: state_nxt = S_WAIT;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_WAIT;
        else     state <= state_nxt;
    end

    // Registered humidity zone; 3 maps to fan-off until the first reading.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) zone <= 2'd3;
        else     zone <= zone_nxt;
    end

    // Sensor watchdog: clocks since the last good sample, parked while faulted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                             wd <= '0;
        else if ((state == S_FAULT) || good) wd <= '0;
        else                                 wd <= wd + WD_W'(1);
    end

    // Consecutive bad-sample counter; idle clocks between strobes do not reset it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                             err_cnt <= '0;
        else if ((state == S_FAULT) || good) err_cnt <= '0;
        else if (bad)                        err_cnt <= err_cnt + 2'd1;
    end

    // Ramp divider runs only while ramping so a retarget keeps its phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            div <= '0;
        else if (ramp_tick) div <= '0;
        else if (ramping)   div <= div + DIV_W'(1);
        else                div <= '0;
    end

    // Duty command, advanced one step per ramp tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  duty <= '0;
        else if (state == S_WAIT) duty <= '0;
        else if (ramp_tick)       duty <= duty_step;
    end

`ifdef FAN_KICK_EN
    localparam logic [KICK_W-1:0] KICK_LAST = KICK_W'(KICK_CYC - 1);

    // Kick-start: remaining ticks to hold full duty after leaving zero; a zero target aborts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  kick_cnt <= '0;
        else if (state == S_WAIT) kick_cnt <= '0;
        else if (ramp_tick) begin
            if (!kick_active && (duty == '0) && (target != '0))
                kick_cnt <= KICK_LAST;
            else if (kick_active)
                kick_cnt <= (target == '0) ? '0 : (kick_cnt - KICK_W'(1));
        end
    end
`else
    assign kick_cnt = '0;
`endif

endmodule

// File: tb/tb_fan_duty_sched.sv
// tb/tb_fan_duty_sched.sv - randomized self-checking bench for fan_duty_sched
module tb_fan_duty_sched;

    localparam int PERIOD      = 1000;
    localparam int RAMP_STEP   = 50;
    localparam int RAMP_DIV    = 4;
    localparam int HYST        = 3;
    localparam int TIMEOUT_CYC = 200;
    localparam int FAULT_DUTY  = 999;
    localparam int KICK_CYC    = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       hum_valid;
    logic [7:0] humidity;
    logic       sensor_err;
    logic [9:0] duty;
    logic [1:0] zone;
    logic       busy;
    logic       fault;
    logic [13:0] obs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign obs = {duty, zone, busy, fault};

    fan_duty_sched #(
        .PERIOD(PERIOD), .RAMP_STEP(RAMP_STEP), .RAMP_DIV(RAMP_DIV), .HYST(HYST),
        .TIMEOUT_CYC(TIMEOUT_CYC), .FAULT_DUTY(FAULT_DUTY), .KICK_CYC(KICK_CYC)
    ) dut (
        .clk(clk), .rst(rst), .hum_valid(hum_valid), .humidity(humidity),
        .sensor_err(sensor_err), .duty(duty), .zone(zone), .busy(busy), .fault(fault)
    );

    // Reference model: behaviour described by modes and integer arithmetic.
    typedef enum int {M_WAIT, M_RAMP, M_HOLD, M_FAULT} mode_t;
    mode_t m_mode;
    int    m_duty, m_zone, m_div, m_wd, m_errs;

    function automatic int zone_of(input int h);
        if (h < 20) return 0;
        if (h < 50) return 1;
        if (h < 80) return 2;
        return 3;
    endfunction

    function automatic int pct_target(input int z);
        int pct;
        pct = (z == 0) ? 20 : (z == 1) ? 50 : (z == 2) ? 80 : 0;
        return (PERIOD - 1) * pct / 100;
    endfunction

    function automatic int m_target();
        return (m_mode == M_FAULT) ? FAULT_DUTY : pct_target(m_zone);
    endfunction

    function automatic logic [13:0] expected();
        return {10'(m_duty), 2'(m_zone), (m_duty != m_target()), (m_mode == M_FAULT)};
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic model_reset();
        m_mode = M_WAIT; m_duty = 0; m_zone = 3; m_div = 0; m_wd = 0; m_errs = 0;
    endtask

    task automatic model_step(input bit hv, input int h, input bit err);
        bit    good, bad, expire, third;
        int    t, nd, nz;
        mode_t nm;
        good   = hv && !err && (h <= 100);
        bad    = hv && !good;
        t      = m_target();
        expire = (m_wd == TIMEOUT_CYC - 1);
        third  = bad && (m_errs == 2);
        nd     = m_duty;
        if (m_mode == M_RAMP || m_mode == M_FAULT) begin
            if (m_div == RAMP_DIV - 1) begin
                nd = (t > m_duty) ? imin(m_duty + RAMP_STEP, t) : imax(m_duty - RAMP_STEP, t);
                m_div = 0;
            end else begin
                m_div++;
            end
        end else begin
            m_div = 0;
        end
        nz = m_zone;
        if (good) begin
            if (m_mode == M_WAIT || m_mode == M_FAULT) nz = zone_of(h);
            else if (zone_of(h) > m_zone)             nz = zone_of(h);
            else if (zone_of(h + HYST) < m_zone)      nz = zone_of(h + HYST);
        end
        nm = m_mode;
        case (m_mode)
            M_WAIT:  if (good) nm = M_RAMP; else if (expire || third) nm = M_FAULT;
            M_RAMP:  if (!good && (expire || third)) nm = M_FAULT;
                     else if (!good && m_duty == t) nm = M_HOLD;
            M_HOLD:  if (good) begin
                         if (pct_target(nz) != m_duty) nm = M_RAMP;
                     end else if (expire || third) nm = M_FAULT;
            M_FAULT: if (good) nm = M_RAMP;
            default: nm = M_WAIT;
        endcase
        if (m_mode == M_FAULT || good) begin m_wd = 0; m_errs = 0; end
        else begin m_wd++; if (bad) m_errs++; end
        m_duty = nd; m_zone = nz; m_mode = nm;
    endtask

    task automatic apply_reset();
        rst = 1'b1; hum_valid = 1'b0; humidity = 8'd0; sensor_err = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic cyc(input bit hv, input int h, input bit err);
        hum_valid = hv; humidity = 8'(h); sensor_err = err;
        @(posedge clk);
        model_step(hv, h, err);
        @(negedge clk);
        hum_valid = 1'b0; humidity = 8'd0; sensor_err = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (duty !== 10'd0) begin errors++; $display("FAIL reset_duty got %0d exp 0", duty); end
        checks++; if (zone !== 2'd3) begin errors++; $display("FAIL reset_zone got %0d exp 3", zone); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0d exp 0", busy); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %0d exp 0", fault); end
    endtask

    task automatic test_ramp_up();
        int vals[$];
        int when[$];
        logic [9:0] last;
        apply_reset();
        cyc(1, 45, 0);
        last = duty;
        for (int i = 0; i < 60; i++) begin
            cyc(0, 0, 0);
            checks++;
            if (obs !== expected()) begin errors++; $display("FAIL ramp_up cyc %0d got %h exp %h", i, obs, expected()); end
            if (duty !== last) begin vals.push_back(int'(duty)); when.push_back(i); last = duty; end
        end
        checks++; if (vals.size() != 10) begin errors++; $display("FAIL ramp_up_steps got %0d exp 10", vals.size()); end
        for (int k = 0; k < vals.size() && k < 10; k++) begin
            checks++;
            if (vals[k] != ((k == 9) ? 499 : 50 * (k + 1))) begin
                errors++; $display("FAIL ramp_up_val %0d got %0d exp %0d", k, vals[k], (k == 9) ? 499 : 50 * (k + 1));
            end
        end
        if (when.size() > 0) begin
            checks++; if (when[0] != RAMP_DIV - 1) begin errors++; $display("FAIL ramp_up_first got %0d exp %0d", when[0], RAMP_DIV - 1); end
        end
        for (int k = 1; k < when.size(); k++) begin
            checks++; if (when[k] - when[k-1] != RAMP_DIV) begin errors++; $display("FAIL ramp_up_gap %0d got %0d exp %0d", k, when[k] - when[k-1], RAMP_DIV); end
        end
        checks++; if ({duty, zone, busy} !== {10'd499, 2'd1, 1'b0}) begin errors++; $display("FAIL ramp_up_hold got %0d/%0d/%0d exp 499/1/0", duty, zone, busy); end
    endtask

    task automatic test_hysteresis();
        cyc(1, 48, 0); repeat (3) cyc(0, 0, 0);
        checks++; if (zone !== 2'd1) begin errors++; $display("FAIL hyst_48 got %0d exp 1", zone); end
        cyc(1, 47, 0); repeat (3) cyc(0, 0, 0);
        checks++; if (zone !== 2'd1) begin errors++; $display("FAIL hyst_47 got %0d exp 1", zone); end
        cyc(1, 16, 0);
        for (int i = 0; i < 40; i++) begin
            cyc(0, 0, 0);
            checks++;
            if (obs !== expected()) begin errors++; $display("FAIL hyst_ramp cyc %0d got %h exp %h", i, obs, expected()); end
        end
        checks++; if ({duty, zone, busy} !== {10'd199, 2'd0, 1'b0}) begin errors++; $display("FAIL hyst_end got %0d/%0d/%0d exp 199/0/0", duty, zone, busy); end
    endtask

    task automatic test_err_fault();
        cyc(1, 30, 1); repeat (2) cyc(0, 0, 0);
        cyc(1, 30, 1); repeat (2) cyc(0, 0, 0);
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL err_two got %0d exp 0", fault); end
        cyc(1, 30, 1);
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL err_three got %0d exp 1", fault); end
        for (int i = 0; i < 20; i++) begin
            cyc(0, 0, 0);
            checks++;
            if (obs !== expected()) begin errors++; $display("FAIL fault_ramp cyc %0d got %h exp %h", i, obs, expected()); end
        end
        checks++; if (duty !== 10'd449) begin errors++; $display("FAIL fault_duty got %0d exp 449", duty); end
        cyc(1, 85, 0);
        checks++; if ({fault, zone} !== {1'b0, 2'd3}) begin errors++; $display("FAIL fault_exit got %0d/%0d exp 0/3", fault, zone); end
        for (int i = 0; i < 50; i++) begin
            cyc(0, 0, 0);
            checks++;
            if (obs !== expected()) begin errors++; $display("FAIL fault_recover cyc %0d got %h exp %h", i, obs, expected()); end
        end
        checks++; if ({duty, busy} !== {10'd0, 1'b0}) begin errors++; $display("FAIL recover_end got %0d/%0d exp 0/0", duty, busy); end
    endtask

    task automatic test_watchdog();
        apply_reset();
        repeat (TIMEOUT_CYC - 1) cyc(0, 0, 0);
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL wd_early got %0d exp 0", fault); end
        cyc(0, 0, 0);
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL wd_expire got %0d exp 1", fault); end
        apply_reset();
        repeat (TIMEOUT_CYC - 1) cyc(0, 0, 0);
        cyc(1, 30, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0);
            checks++;
            if ({fault, zone} !== {1'b0, 2'd1}) begin errors++; $display("FAIL wd_race cyc %0d got %0d/%0d exp 0/1", i, fault, zone); end
        end
    endtask

    task automatic test_bad_range();
        repeat (50) cyc(0, 0, 0);
        cyc(1, 101, 0);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 0);
            checks++;
            if ({duty, zone} !== {10'd499, 2'd1}) begin errors++; $display("FAIL over100 cyc %0d got %0d/%0d exp 499/1", i, duty, zone); end
        end
        cyc(1, 70, 0);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 0);
            checks++;
            if (obs !== expected()) begin errors++; $display("FAIL pre_reset cyc %0d got %h exp %h", i, obs, expected()); end
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs !== {10'd0, 2'd3, 1'b0, 1'b0}) begin errors++; $display("FAIL async_reset got %h exp %h", obs, {10'd0, 2'd3, 2'b00}); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_back_to_back();
        int hs[6] = '{45, 60, 85, 10, 33, 72};
        apply_reset();
        foreach (hs[k]) begin
            cyc(1, hs[k], 0);
            checks++;
            if (obs !== expected()) begin errors++; $display("FAIL b2b strobe %0d got %h exp %h", k, obs, expected()); end
        end
        for (int i = 0; i < 80; i++) begin
            cyc(0, 0, 0);
            checks++;
            if (obs !== expected()) begin errors++; $display("FAIL b2b cyc %0d got %h exp %h", i, obs, expected()); end
        end
    endtask

    task automatic test_random();
        int rates[3] = '{3, 20, 150};
        bit hv, err;
        int h;
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            hv  = ($urandom_range(0, rates[(i / 500) % 3] - 1) == 0);
            h   = $urandom_range(0, 110);
            err = ($urandom_range(0, 5) == 0);
            cyc(hv, h, err);
            checks++;
            if (obs !== expected()) begin errors++; $display("FAIL random cyc %0d got %h exp %h", i, obs, expected()); end
        end
    endtask

    task automatic test_kick();
        int e;
        apply_reset();
        cyc(1, 10, 0);
        for (int i = 1; i <= 80; i++) begin
            cyc(0, 0, 0);
            e = (i < 4) ? 0 : (i < 12) ? 999 : imax(999 - 50 * ((i - 8) / 4), 199);
            checks++;
            if ({duty, busy} !== {10'(e), (e != 199)}) begin errors++; $display("FAIL kick cyc %0d got %0d/%0d exp %0d/%0d", i, duty, busy, e, e != 199); end
        end
    endtask

    initial begin
        rst = 1'b1; hum_valid = 1'b0; humidity = 8'd0; sensor_err = 1'b0;
        model_reset();
        test_reset();
`ifdef FAN_KICK_EN
        test_kick();
`else
        test_ramp_up();
        test_hysteresis();
        test_err_fault();
        test_watchdog();
        test_bad_range();
        test_back_to_back();
        test_random();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1);
    end

endmodule
